// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: one data-RAM access at a time over mem_req/mem_ack, with sb/lbu lane steering and a timeout abort.
// Optional MISALIGN_TRAP_EN: misaligned lw/sw is trapped with err instead of being forced to word alignment.
module lsu_mem_ctrl #(
  parameter  int TIMEOUT = 16,
  localparam int CNT_W   = $clog2(TIMEOUT) + 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_oeram,
  input  logic        i_weram,
  input  logic        i_lwlbu,
  input  logic        i_st_byte,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_load_data,
  output logic        o_err,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_wmask,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ack
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_is_load, r_lbu;
  logic [1:0]        r_boff;
  logic              r_done, r_err, r_mem_req, r_mem_we;
  logic [31:0]       r_load_data, r_mem_addr, r_mem_wdata;
  logic [3:0]        r_mem_wmask;

  logic w_accept, w_ack, w_tmo, w_misalign;
  logic [7:0] w_rbyte;

  assign w_accept = (r_state == S_IDLE) && i_start && (i_oeram ^ i_weram);
  assign w_ack    = (r_state == S_ACCESS) && i_mem_ack;
  // Ack on the last allowed cycle still wins over the timeout.
  assign w_tmo    = (r_state == S_ACCESS) && !i_mem_ack && (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_rbyte  = i_mem_rdata[8*r_boff +: 8];

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = (i_addr[1:0] != 2'b00) &&
                      ((i_weram && !i_st_byte) || (i_oeram && !i_lwlbu));
`else
  assign w_misalign = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = w_misalign ? S_RESP : S_ACCESS;
      S_ACCESS: if (w_ack || w_tmo) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      r_is_load   <= 1'b0;
      r_lbu       <= 1'b0;
      r_boff      <= 2'b00;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_load_data <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wmask <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_done <= (r_state == S_RESP);
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_is_load <= i_oeram;
          r_lbu     <= i_lwlbu;
          r_boff    <= i_addr[1:0];
          r_cnt     <= '0;
          r_err     <= w_misalign;
          if (w_misalign) begin
            r_load_data <= '0;
          end else begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= i_weram;
            r_mem_addr  <= {i_addr[31:2], 2'b00};
            r_mem_wmask <= !i_weram ? 4'b0000 : (i_st_byte ? 4'b0001 << i_addr[1:0] : 4'b1111);
            r_mem_wdata <= !i_weram ? 32'h0 : (i_st_byte ? {4{i_wdata[7:0]}} : i_wdata);
          end
        end
        S_ACCESS: begin
          if (w_ack) begin
            r_mem_req <= 1'b0;
            if (r_is_load) r_load_data <= r_lbu ? {24'h0, w_rbyte} : i_mem_rdata;
          end else if (w_tmo) begin
            r_mem_req   <= 1'b0;
            r_err       <= 1'b1;
            r_load_data <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_load_data = r_load_data;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wmask = r_mem_wmask;
  assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed scenarios plus random ops against a transaction-level model.
module tb_lsu_mem_ctrl;
  localparam int TIMEOUT = 16;

  logic        clk, rst_n, start, oeram, weram, lwlbu, st_byte, mem_ack;
  logic [31:0] addr, wdata, mem_rdata;
  logic        busy, done, err, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;

  int n_chk = 0, n_fail = 0;
  logic [31:0] exp_ld = 0;

  lsu_mem_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_oeram(oeram), .i_weram(weram),
    .i_lwlbu(lwlbu), .i_st_byte(st_byte), .i_addr(addr), .i_wdata(wdata),
    .o_busy(busy), .o_done(done), .o_load_data(load_data), .o_err(err),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wmask(mem_wmask), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One access; dly = cycles of ack delay, negative = never ack.
  task automatic run_op(input bit ld, input bit byt, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int dly);
    bit mis, to, got_done, seen_req;
    int req_cyc, busy_bad, done_cyc, exp_lat;
    logic [3:0] exp_mask;
    logic [31:0] exp_wd;
`ifdef MISALIGN_TRAP_EN
    mis = !byt && (a % 4 != 0);
`else
    mis = 0;
`endif
    to       = !mis && (dly < 0 || dly >= TIMEOUT);
    exp_mask = ld ? 4'd0 : (byt ? 4'(1 << (a % 4)) : 4'hF);
    exp_wd   = byt ? (wd & 32'hFF) * 32'h01010101 : wd;
    exp_lat  = mis ? 1 : (to ? TIMEOUT + 1 : dly + 2);
    req_cyc = 0; busy_bad = 0; done_cyc = -1; got_done = 0; seen_req = 0;

    @(negedge clk);
    start = 1; oeram = ld; weram = !ld; lwlbu = byt; st_byte = byt; addr = a; wdata = wd;
    @(posedge clk);
    for (int c = 0; c < TIMEOUT + 8 && !got_done; c++) begin
      @(negedge clk);
      start = 0; oeram = 0; weram = 0;
      if (done) begin
        got_done = 1; done_cyc = c;
      end else begin
        if (!busy) busy_bad++;
        if (mem_req) begin
          req_cyc++;
          if (!seen_req) begin
            seen_req = 1;
            chk("mem_we", 32'(mem_we), 32'(!ld));
            chk("mem_addr", mem_addr, a & ~32'h3);
            chk("mem_wmask", 32'(mem_wmask), 32'(exp_mask));
            if (!ld) chk("mem_wdata", mem_wdata, exp_wd);
          end
        end
      end
      mem_ack   = (dly >= 0 && c == dly && mem_req);
      mem_rdata = mem_ack ? rd : $urandom;
    end
    mem_ack = 0;
    if (ld && !to && !mis) exp_ld = byt ? (rd >> (8 * (a % 4))) & 32'hFF : rd;
    else if (to || mis)    exp_ld = 0;
    chk("done_lat", 32'(done_cyc), 32'(exp_lat));
    chk("req_cycles", 32'(req_cyc), 32'(mis ? 0 : (to ? TIMEOUT : dly + 1)));
    chk("busy_held", 32'(busy_bad), 0);
    chk("err", 32'(err), 32'(to || mis));
    chk("load_data", load_data, exp_ld);
    @(negedge clk);
    chk("done_pulse", 32'(done), 0);
  endtask

  task automatic ignored_start(input bit both);
    logic e0;
    e0 = err;
    @(negedge clk);
    start = 1; oeram = both; weram = both;
    @(negedge clk);
    start = 0; oeram = 0; weram = 0;
    chk("ign_busy", 32'(busy), 0);
    chk("ign_req", 32'(mem_req), 0);
    chk("ign_err", 32'(err), 32'(e0));
    @(negedge clk);
    chk("ign_done", 32'(done), 0);
  endtask

  initial begin
    int seen_done;
    rst_n = 0; start = 0; oeram = 0; weram = 0; lwlbu = 0; st_byte = 0;
    addr = 0; wdata = 0; mem_rdata = 0; mem_ack = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_ld", load_data, 0);
    chk("rst_wmask", 32'(mem_wmask), 0);
    rst_n = 1;

    run_op(0, 0, 32'h104, 32'hDEADBEEF, 0, 1);           // sw
    run_op(0, 1, 32'h103, 32'h000000A5, 0, 0);           // sb
    run_op(1, 1, 32'h102, 32'h0, 32'h11223344, 3);       // lbu
    run_op(1, 0, 32'h200, 32'h0, 32'h0, -1);             // lw timeout
    ignored_start(1);
    ignored_start(0);
    run_op(1, 0, 32'h200, 32'h0, 32'hCAFEF00D, 2);       // err clears
    run_op(1, 0, 32'h300, 32'h0, 32'h55AA55AA, TIMEOUT - 1); // ack on last cycle wins
    run_op(1, 0, 32'h202, 32'h0, 32'h0BADF00D, 0);       // misaligned lw

    // reset in the middle of an access
    @(negedge clk);
    start = 1; oeram = 1; weram = 0; lwlbu = 0; addr = 32'h400;
    @(negedge clk);
    start = 0; oeram = 0;
    chk("pre_rst_req", 32'(mem_req), 1);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    exp_ld = 0;
    chk("midrst_req", 32'(mem_req), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ld", load_data, 0);
    seen_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    chk("midrst_nodone", 32'(seen_done), 0);
    ignored_start(1);

    for (int i = 0; i < 24; i++) begin
      bit ld, byt;
      int d;
      ld  = 1'($urandom_range(0, 1));
      byt = 1'($urandom_range(0, 1));
      d   = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
      run_op(ld, byt, $urandom, $urandom, $urandom, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
